tinyalu_cmd_dispatch: RTL and testbench

//  Upstream command stage for TinyALU. Buffers {op,A,B} commands in a small FIFO,

---
 rtl/tinyalu_pkg.sv | 31 +++
 rtl/tinyalu_cmd_fifo.sv | 56 +++++
 rtl/tinyalu_cmd_dispatch.sv | 173 +++++++++++++++++
 tb/tb_tinyalu_cmd_dispatch.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: ALU operation encoding, queued command record and dispatcher states.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100
    } operation_t;

    // op is kept as raw bits so that illegal encodings survive the FIFO and can be flagged
    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dispatch_state_t;

    localparam logic [15:0] TIMEOUT_RESULT = 16'hDEAD;

    function automatic logic is_legal_op(input logic [2:0] op_bits);
        return op_bits <= MUL_OP;
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Command FIFO for the TinyALU dispatcher; DEPTH must be a power of two >= 2.
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     push,
    input  alu_cmd_t wdata,
    input  logic     pop,
    output alu_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    // one extra pointer bit separates full from empty when the indices match
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    alu_cmd_t    mem_q [DEPTH];
    alu_cmd_t    mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/tinyalu_cmd_dispatch.sv
// TinyALU command dispatcher: queues commands, runs one ALU start/done handshake at a time.
// Define TINYALU_DISPATCH_TIMEOUT_EN to abort a command when done does not arrive in time.
//
// state | meaning
// IDLE  | pop next command; no_op/illegal are dropped here
// ISSUE | start held high with stable A/B/op, waiting for done
// RESP  | result held on rsp_* until the consumer takes it
module tinyalu_cmd_dispatch
    import tinyalu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  op,
    output logic        start,
    input  logic        done,
    input  logic [15:0] result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        err_illegal,
    output logic        err_timeout
);

    dispatch_state_t state_q, state_d;
    logic [7:0]      a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d, rsp_op_q, rsp_op_d;
    logic            start_q, start_d, rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic            err_illegal_q, err_illegal_d;
    logic            fifo_full, fifo_empty, fifo_pop;
    alu_cmd_t        head;

`ifdef TINYALU_DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q, err_timeout_d;
`endif

    assign cmd_ready = reset_n && !fifo_full;

    tinyalu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (cmd_valid && cmd_ready),
        .wdata  ('{op: cmd_op, a: cmd_a, b: cmd_b}),
        .pop    (fifo_pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        start_d       = start_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_op_d      = rsp_op_q;
        err_illegal_d = err_illegal_q;
        fifo_pop      = 1'b0;
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (!is_legal_op(head.op)) begin
                        err_illegal_d = 1'b1;
                    end else if (head.op != NO_OP) begin
                        a_d     = head.a;
                        b_d     = head.b;
                        op_d    = head.op;
                        start_d = 1'b1;
                        state_d = ISSUE;
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                    end
                end
            end
            ISSUE: begin
                if (done) begin
                    start_d      = 1'b0;
                    rsp_result_d = result;
                    rsp_op_d     = op_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    start_d       = 1'b0;
                    rsp_result_d  = TIMEOUT_RESULT;
                    rsp_op_d      = op_q;
                    rsp_valid_d   = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_op_q      <= '0;
            err_illegal_q <= 1'b0;
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            start_q       <= start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_op_q      <= rsp_op_d;
            err_illegal_q <= err_illegal_d;
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign A           = a_q;
    assign B           = b_q;
    assign op          = op_q;
    assign start       = start_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
    assign err_illegal = err_illegal_q;
`ifdef TINYALU_DISPATCH_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tinyalu_cmd_dispatch.sv
// Directed bench for tinyalu_cmd_dispatch with a behavioural ALU on the start/done pins.
module tb_tinyalu_cmd_dispatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [7:0]  A, B;
    logic [2:0]  op;
    logic        start;
    logic        done = 1'b0;
    logic [15:0] result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        err_illegal, err_timeout;

    int n_checks = 0;
    int n_err = 0;

    // behavioural ALU controls
    logic alu_en = 1'b1;
    int   alu_lat = 2;
    logic spurious = 1'b0;
    int   alu_cnt = 0;

    // start-gap monitor
    logic mon_en = 1'b0;
    logic prev_start = 1'b0;
    int   n_rises = 0;
    int   low_run = 0;
    int   min_gap = 1000;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    tinyalu_cmd_dispatch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .A          (A),
        .B          (B),
        .op         (op),
        .start      (start),
        .done       (done),
        .result     (result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (spurious) begin
            done   = 1'b1;
            result = 16'h1234;
        end else if (start && alu_en) begin
            if (alu_cnt >= alu_lat) begin
                done    = 1'b1;
                result  = alu_fn(op, A, B);
                alu_cnt = 0;
            end else begin
                done    = 1'b0;
                alu_cnt = alu_cnt + 1;
            end
        end else begin
            done    = 1'b0;
            alu_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!mon_en) begin
            n_rises = 0;
            low_run = 0;
            min_gap = 1000;
        end else if (start) begin
            if (!prev_start && n_rises > 0 && low_run < min_gap) min_gap = low_run;
            if (!prev_start) n_rises = n_rises + 1;
            low_run = 0;
        end else begin
            low_run = low_run + 1;
        end
        prev_start = start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = o;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("push cmd_ready timeout", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [15:0] er, input logic [2:0] eo);
        int n = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, " rsp_valid"}, 32'(rsp_valid), 1);
        if (rsp_valid) begin
            chk({name, " rsp_result"}, 32'(rsp_result), 32'(er));
            chk({name, " rsp_op"}, 32'(rsp_op), 32'(eo));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{3'b001, 8'h12, 8'h34, 16'h0046};
        vecs[1] = '{3'b010, 8'hF0, 8'h3C, 16'h0030};
        vecs[2] = '{3'b011, 8'hAA, 8'h55, 16'h00FF};
        vecs[3] = '{3'b100, 8'hFF, 8'hFF, 16'hFE01};
        vecs[4] = '{3'b001, 8'hFF, 8'hFF, 16'h01FE};
        vecs[5] = '{3'b100, 8'h10, 8'h10, 16'h0100};
        vecs[6] = '{3'b100, 8'h00, 8'h77, 16'h0000};

        // reset values
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst start", 32'(start), 0);
        chk("rst rsp_valid", 32'(rsp_valid), 0);
        chk("rst cmd_ready", 32'(cmd_ready), 0);
        chk("rst A/B/op", {13'h0, A, B, op}, 0);
        chk("rst rsp_result/op", {13'h0, rsp_result, rsp_op}, 0);
        chk("rst err", {30'h0, err_illegal, err_timeout}, 0);
        reset_n = 1'b1;
        #1;
        chk("post-rst cmd_ready", 32'(cmd_ready), 1);

        // 1: single add, latency and hold while rsp_ready low
        push_cmd(3'b001, 8'h12, 8'h34);
        chk("t1 start not yet", 32'(start), 0);
        @(posedge clk);
        #1;
        chk("t1 start", 32'(start), 1);
        chk("t1 A/B/op", {13'h0, A, B, op}, {13'h0, 8'h12, 8'h34, 3'b001});
        n = 0;
        @(negedge clk);
        #1;
        while (!done && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t1 done seen", 32'(done), 1);
        @(posedge clk);
        #1;
        chk("t1 rsp_valid after done edge", 32'(rsp_valid), 1);
        chk("t1 start dropped", 32'(start), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1 rsp held", {15'h0, rsp_valid, rsp_result}, {15'h0, 1'b1, 16'h0046});
        get_rsp("t1", 16'h0046, 3'b001);

        // table vectors, one command at a time
        for (int i = 0; i < 7; i++) begin
            push_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
            get_rsp($sformatf("vec%0d", i), vecs[i].exp, vecs[i].op);
        end

        // 2: back-to-back mul then xor
        rsp_ready = 1'b1;
        mon_en = 1'b1;
        push_cmd(3'b100, 8'hFF, 8'hFF);
        push_cmd(3'b011, 8'hF0, 8'h0F);
        get_rsp("t2 mul", 16'hFE01, 3'b100);
        get_rsp("t2 xor", 16'h00FF, 3'b011);
        @(negedge clk);
        chk("t2 start rises", 32'(n_rises), 2);
        chk("t2 start low gap>=2", 32'(min_gap >= 2), 1);
        mon_en = 1'b0;

        // 3: full FIFO with response stalled
        rsp_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_cmd(3'b001, 8'(i), 8'(i * 16));
        chk("t3 cmd_ready full", 32'(cmd_ready), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("t3 still full", 32'(cmd_ready), 0);
        chk("t3 first rsp held", {15'h0, rsp_valid, rsp_result}, {15'h0, 1'b1, 16'h0011});
        for (int i = 1; i <= 5; i++) get_rsp($sformatf("t3 rsp%0d", i), 16'(i * 17), 3'b001);
        chk("t3 drained", {30'h0, cmd_ready, rsp_valid}, {30'h0, 1'b1, 1'b0});

        // 4: no_op and illegal are dropped, illegal is sticky
        chk("t4 err_illegal before", 32'(err_illegal), 0);
        push_cmd(3'b000, 8'h01, 8'h01);
        push_cmd(3'b110, 8'h01, 8'h01);
        push_cmd(3'b001, 8'h01, 8'h01);
        get_rsp("t4 add", 16'h0002, 3'b001);
        repeat (8) @(posedge clk);
        #1;
        chk("t4 no extra rsp", {30'h0, rsp_valid, start}, 0);
        chk("t4 err_illegal", 32'(err_illegal), 1);
        spurious = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spurious = 1'b0;
        chk("t4 stray done ignored", {30'h0, rsp_valid, start}, 0);
        chk("t4 err_illegal sticky", 32'(err_illegal), 1);

        // 5: reset during a mul with more commands queued
        alu_lat = 8;
        rsp_ready = 1'b1;
        push_cmd(3'b100, 8'h0F, 8'h0F);
        push_cmd(3'b001, 8'h01, 8'h01);
        push_cmd(3'b001, 8'h02, 8'h02);
        n = 0;
        while (!start && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5 start before reset", 32'(start), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 start cleared", 32'(start), 0);
        chk("t5 rsp_valid cleared", 32'(rsp_valid), 0);
        chk("t5 cmd_ready in reset", 32'(cmd_ready), 0);
        chk("t5 A/B/op cleared", {13'h0, A, B, op}, 0);
        chk("t5 err_illegal cleared", 32'(err_illegal), 0);
        @(negedge clk);
        reset_n = 1'b1;
        alu_lat = 2;
        repeat (6) @(posedge clk);
        #1;
        chk("t5 queue flushed", {30'h0, start, rsp_valid}, 0);
        chk("t5 cmd_ready", 32'(cmd_ready), 1);
        push_cmd(3'b001, 8'h02, 8'h03);
        get_rsp("t5 add", 16'h0005, 3'b001);

`ifdef TINYALU_DISPATCH_TIMEOUT_EN
        // 6: ALU never answers
        alu_en = 1'b0;
        rsp_ready = 1'b0;
        push_cmd(3'b001, 8'h03, 8'h04);
        n = 0;
        while (!start && n < 5) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6 start", 32'(start), 1);
        repeat (15) @(posedge clk);
        #1;
        chk("t6 still waiting", {30'h0, start, rsp_valid}, {30'h0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        chk("t6 timed out", {30'h0, start, rsp_valid}, {30'h0, 1'b0, 1'b1});
        chk("t6 err_timeout", 32'(err_timeout), 1);
        get_rsp("t6", 16'hDEAD, 3'b001);
        alu_en = 1'b1;
        chk("t6 err_timeout sticky", 32'(err_timeout), 1);
`else
        chk("err_timeout tied low", 32'(err_timeout), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
